// File: rtl/csr_dfh_responder.sv
// csr_dfh_responder: 64-bit AXI4-Lite CSR target for one DFH feature window.
// Optional access counter at offset 0x20 enabled by CSR_DFH_RESP_ACCESS_CNT_EN.
module csr_dfh_responder #(
    parameter int                ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h10000,
    parameter logic [63:0]       DFH_VALUE = 64'h3000_0000_1000_0020,
    parameter logic [63:0]       GUID_L    = 64'h0,
    parameter logic [63:0]       GUID_H    = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp
);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e          w_q, w_d;
    r_state_e          r_q, r_d;
    logic [ADDR_W-1:3] awaddr_q, wa;
    logic [63:0]       wdata_q, wd, wmask;
    logic [7:0]        wstrb_q, ws;
    logic [1:0]        bresp_q, rresp_q;
    logic [63:0]       rdata_q, rd_val, cnt;
    logic [63:0]       scratch_q, scratch_d, test_q, test_d;
    logic              aw_hs, w_hs, ar_hs, upd, in_w, in_r;
    logic [12:0]       woff, roff;
    logic              unused_lsb;

    assign unused_lsb = &{1'b0, awaddr[2:0], araddr[2:0]};

    assign awready = rst_n && (w_q == W_IDLE || w_q == W_DATA);
    assign wready  = rst_n && (w_q == W_IDLE || w_q == W_ADDR);
    assign arready = rst_n && (r_q == R_IDLE);
    assign bvalid  = (w_q == W_RESP);
    assign rvalid  = (r_q == R_DATA);
    assign bresp   = bresp_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // The half captured earlier comes from the holding registers, the other half is live.
    assign wa   = (w_q == W_ADDR) ? awaddr_q : awaddr[ADDR_W-1:3];
    assign wd   = (w_q == W_DATA) ? wdata_q : wdata;
    assign ws   = (w_q == W_DATA) ? wstrb_q : wstrb;
    assign in_w = (wa[ADDR_W-1:16] == BASE_ADDR[ADDR_W-1:16]);
    assign woff = wa[15:3];
    assign in_r = (araddr[ADDR_W-1:16] == BASE_ADDR[ADDR_W-1:16]);
    assign roff = araddr[15:3];

    always_comb begin
        w_d = w_q;
        upd = 1'b0;
        case (w_q)
            W_IDLE: begin
                w_d = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_ADDR : w_hs ? W_DATA : W_IDLE;
                upd = aw_hs && w_hs;
            end
            W_ADDR: begin
                w_d = w_hs ? W_RESP : W_ADDR;
                upd = w_hs;
            end
            W_DATA: begin
                w_d = aw_hs ? W_RESP : W_DATA;
                upd = aw_hs;
            end
            default: w_d = bready ? W_IDLE : W_RESP;
        endcase
    end

    always_comb begin
        r_d = (r_q == R_IDLE) ? (arvalid ? R_DATA : R_IDLE) : (rready ? R_IDLE : R_DATA);
    end

    always_comb begin
        for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{ws[i]}};
        scratch_d = (upd && in_w && woff == 13'h3) ? (scratch_q & ~wmask) | (wd & wmask) : scratch_q;
        test_d    = (upd && in_w && woff == 13'h7) ? (test_q & ~wmask) | (wd & wmask) : test_q;
    end

    always_comb begin
        rd_val = !in_r          ? 64'h0     :
                 roff == 13'h0 ? DFH_VALUE :
                 roff == 13'h1 ? GUID_L    :
                 roff == 13'h2 ? GUID_H    :
                 roff == 13'h3 ? scratch_q :
                 roff == 13'h4 ? cnt       :
                 roff == 13'h7 ? test_q    : 64'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q       <= W_IDLE;
            r_q       <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            scratch_q <= '0;
            test_q    <= '0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            scratch_q <= scratch_d;
            test_q    <= test_d;
            if (aw_hs) awaddr_q <= awaddr[ADDR_W-1:3];
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (upd) bresp_q <= in_w ? 2'b00 : 2'b10;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= in_r ? 2'b00 : 2'b10;
            end
        end
    end

`ifdef CSR_DFH_RESP_ACCESS_CNT_EN
    logic [63:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_q + 64'(bvalid && bready) + 64'(rvalid && rready);
    end
    assign cnt = cnt_q;
`else
    assign cnt = '0;
`endif
endmodule

// File: tb/tb_csr_dfh_responder.sv
// tb_csr_dfh_responder: directed self-checking bench for csr_dfh_responder.
module tb_csr_dfh_responder;
`ifdef CSR_DFH_RESP_ACCESS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [63:0] DFH = 64'h3000_0000_1000_0020;
    localparam logic [63:0] GL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] GH  = 64'hFEDC_BA98_7654_3210;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [19:0] awaddr = '0, araddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    int          vec = 0, errs = 0;
    longint      acc = 0;

    always #5 clk = ~clk;

    csr_dfh_responder #(.GUID_L(GL), .GUID_H(GH)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [19:0] a, input logic [63:0] ed, input logic [1:0] er);
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        chk({tag, ".arready"}, 64'(arready), 64'h1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".rvalid"}, 64'(rvalid), 64'h1);
        chk({tag, ".rdata"}, rdata, ed);
        chk({tag, ".rresp"}, 64'(rresp), 64'(er));
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        acc++;
        chk({tag, ".rvalid_drop"}, 64'(rvalid), 64'h0);
    endtask

    task automatic wr(input string tag, input logic [19:0] a, input logic [63:0] d, input logic [7:0] s,
                      input logic [1:0] er);
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".bvalid"}, 64'(bvalid), 64'h1);
        chk({tag, ".bresp"}, 64'(bresp), 64'(er));
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        acc++;
        chk({tag, ".bvalid_drop"}, 64'(bvalid), 64'h0);
    endtask

    initial begin
        #3;
        chk("rst.awready", 64'(awready), 64'h0);
        chk("rst.wready", 64'(wready), 64'h0);
        chk("rst.arready", 64'(arready), 64'h0);
        chk("rst.bvalid", 64'(bvalid), 64'h0);
        chk("rst.rvalid", 64'(rvalid), 64'h0);
        chk("rst.rdata", rdata, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rd("dfh", 20'h10000, DFH, 2'b00);
        rd("guid_l", 20'h10008, GL, 2'b00);
        rd("guid_h", 20'h10010, GH, 2'b00);

        wr("scr_w1", 20'h10018, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2'b00);
        rd("scr_r1", 20'h10018, 64'hDEADBEEF_CAFEF00D, 2'b00);
        wr("scr_w2", 20'h1001F, 64'h11223344_55667788, 8'h0F, 2'b00);
        rd("scr_r2", 20'h10018, 64'hDEADBEEF_55667788, 2'b00);

        @(negedge clk);
        awaddr  = 20'h10038;
        awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("awfirst.bvalid_wait", 64'(bvalid), 64'h0);
            chk("awfirst.awready_wait", 64'(awready), 64'h0);
            chk("awfirst.wready_wait", 64'(wready), 64'h1);
        end
        wdata  = 64'hA5A5_A5A5_A5A5_A5A5;
        wstrb  = 8'hFF;
        wvalid = 1'b1;
        @(posedge clk);
        #1 wvalid = 1'b0;
        @(negedge clk);
        chk("awfirst.bvalid", 64'(bvalid), 64'h1);
        repeat (4) begin
            @(negedge clk);
            chk("awfirst.bvalid_hold", 64'(bvalid), 64'h1);
            chk("awfirst.bresp_hold", 64'(bresp), 64'h0);
        end
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        acc++;
        chk("awfirst.bvalid_drop", 64'(bvalid), 64'h0);
        rd("awfirst.tp", 20'h10038, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00);

        @(negedge clk);
        wdata  = 64'h0102_0304_0506_0708;
        wstrb  = 8'hF0;
        wvalid = 1'b1;
        @(posedge clk);
        #1 wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("wfirst.bvalid_wait", 64'(bvalid), 64'h0);
            chk("wfirst.wready_wait", 64'(wready), 64'h0);
            chk("wfirst.awready_wait", 64'(awready), 64'h1);
        end
        awaddr  = 20'h10038;
        awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        @(negedge clk);
        chk("wfirst.bvalid", 64'(bvalid), 64'h1);
        chk("wfirst.bresp", 64'(bresp), 64'h0);
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        acc++;
        chk("wfirst.bvalid_drop", 64'(bvalid), 64'h0);
        rd("wfirst.tp", 20'h10038, 64'h0102_0304_A5A5_A5A5, 2'b00);

        rd("oow_rd", 20'h20000, 64'h0, 2'b10);
        wr("oow_wr", 20'h20018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10);
        rd("oow_scr", 20'h10018, 64'hDEADBEEF_55667788, 2'b00);
        rd("hole", 20'h10100, 64'h0, 2'b00);
        wr("ro_wr", 20'h10000, 64'h0, 8'hFF, 2'b00);
        rd("ro_dfh", 20'h10000, DFH, 2'b00);
        wr("strb0", 20'h10018, 64'h0, 8'h00, 2'b00);
        rd("strb0_scr", 20'h10018, 64'hDEADBEEF_55667788, 2'b00);

        @(negedge clk);
        awaddr  = 20'h10018;
        wdata   = 64'h1234;
        wstrb   = 8'hFF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("arst.bvalid_pend", 64'(bvalid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.bvalid", 64'(bvalid), 64'h0);
        chk("arst.awready", 64'(awready), 64'h0);
        chk("arst.arready", 64'(arready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 0;
        rd("arst.scr", 20'h10018, 64'h0, 2'b00);
        rd("arst.tp", 20'h10038, 64'h0, 2'b00);

        wr("cnt.w1", 20'h10038, 64'h77, 8'h01, 2'b00);
        wr("cnt.w2", 20'h10020, 64'hFFFF, 8'hFF, 2'b00);
        wr("cnt.w3", 20'h20018, 64'h1, 8'hFF, 2'b10);
        rd("cnt.r5", 20'h10020, CNT_EN ? 64'd5 : 64'h0, 2'b00);
        wr("same.pre", 20'h10018, 64'h5, 8'hFF, 2'b00);

        @(negedge clk);
        araddr  = 20'h10018;
        arvalid = 1'b1;
        awaddr  = 20'h10018;
        wdata   = 64'h9;
        wstrb   = 8'hFF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("same.rvalid", 64'(rvalid), 64'h1);
        chk("same.rdata_old", rdata, 64'h5);
        chk("same.bvalid", 64'(bvalid), 64'h1);
        rready = 1'b1;
        bready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        bready = 1'b0;
        acc += 2;
        chk("same.rvalid_drop", 64'(rvalid), 64'h0);
        rd("same.new", 20'h10018, 64'h9, 2'b00);
        rd("cnt.after2", 20'h10020, CNT_EN ? 64'(acc) : 64'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
